// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_pkg
//  Purpose  : Shared types and constants for the ADC128S022 frame reader.
//             Frame state encoding, frame geometry and the address-bit
//             helper used when driving ADC_SADDR.
//  Revision : 1.0 - initial release
// ============================================================================
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } adc_state_t;

  typedef logic [2:0] adc_ch_t;

  localparam int unsigned ADC_BITS   = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LEAD_ZEROS = 4;

  // Value of ADC DIN during frame bit k: ADD2/ADD1/ADD0 sit in bits 2..4,
  // every other bit of the frame is a don't-care that we keep at 0.
  function automatic logic addr_bit(input logic [3:0] k, input adc_ch_t ch);
    logic b;
    b = 1'b0;
    case (k)
      4'd2:    b = ch[2];
      4'd3:    b = ch[1];
      4'd4:    b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc128s022_reader_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sclk_gen
//  Purpose  : Half-period timer and SCLK level register for one ADC frame.
//             The counter is cleared when a frame starts so every frame has
//             identical timing regardless of what happened before.
//  Ports    : clk         - system clock
//             reset       - synchronous active-high reset
//             i_restart   - clear the counter and force SCLK high
//             i_run       - count while a frame is active
//             i_toggle    - invert SCLK at the end of the current half period
//             o_half_tick - last clk cycle of a half period
//             o_sclk      - registered SCLK level (idles high)
//  Revision : 1.0 - initial release
// ============================================================================
module sclk_gen #(
  parameter int CLK_DIV = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  input  logic i_run,
  input  logic i_toggle,
  output logic o_half_tick,
  output logic o_sclk
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (i_restart) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (i_run) begin
      if (r_cnt == C_LAST) begin
        r_cnt <= '0;
        if (i_toggle) begin
          r_sclk <= ~r_sclk;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_half_tick = i_run && (r_cnt == C_LAST);
  assign o_sclk      = r_sclk;

endmodule
`default_nettype wire

// File: rtl/adc128s022_reader.sv
`default_nettype none
// ============================================================================
//  Module   : adc128s022_reader
//  Purpose  : Runs one 16-bit ADC128S022 frame per accepted start and
//             returns the converted sample tagged with its channel.
//             The ADC converts the channel addressed in the previous frame,
//             so channel_o reports the channel latched one frame earlier.
//  Ports    : clk        - system clock (CLK50MHZ)
//             reset      - synchronous active-high reset
//             start_i    - request a frame, honoured only while not busy
//             channel_i  - channel addressed by the requested frame
//             sample_o   - last converted sample, held between valid pulses
//             channel_o  - channel sample_o belongs to
//             valid_o    - one-cycle pulse when sample_o/channel_o update
//             busy_o     - frame in progress
//             ADC_CS_N   - chip select, active low
//             ADC_SCLK   - serial clock, idles high
//             ADC_SADDR  - ADC DIN (address)
//             ADC_SDAT   - ADC DOUT
//  Revision : 1.0 - initial release
// ============================================================================
module adc128s022_reader #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  channel_i,
  output logic [11:0] sample_o,
  output logic [2:0]  channel_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        ADC_CS_N,
  output logic        ADC_SCLK,
  output logic        ADC_SADDR,
  input  logic        ADC_SDAT
);

  import adc_pkg::*;

  localparam logic [3:0] c_last_bit = 4'(FRAME_BITS - 1);
  localparam logic [3:0] c_lead     = 4'(LEAD_ZEROS);

  adc_state_t          r_state, w_state_nxt;
  logic [3:0]          r_bit, w_bit_nxt;
  adc_ch_t             r_ch, w_ch_nxt;
  adc_ch_t             r_prev_ch, w_prev_nxt;
  logic [ADC_BITS-1:0] r_shreg, w_shreg_nxt;
  logic                r_sdat_q;
  logic                r_cs_n, w_cs_n_nxt;
  logic                r_saddr, w_saddr_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic [ADC_BITS-1:0] r_sample, w_sample_nxt;
  adc_ch_t             r_channel, w_chan_nxt;

  logic w_accept;
  logic w_restart;
  logic w_run;
  logic w_toggle;
  logic w_half_tick;
  logic w_sclk;

  // busy is low in IDLE and DONE, so a start in the valid cycle is accepted.
  assign w_accept = start_i && !r_busy;
  assign w_run    = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
  // SETUP ends with the first falling edge; the final high half of SHIFT
  // must not toggle so SCLK is already high when CS_N rises.
  assign w_toggle = (r_state == SETUP) ||
                    ((r_state == SHIFT) && !(w_sclk && (r_bit == c_last_bit)));

  sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .reset       (reset),
    .i_restart   (w_restart),
    .i_run       (w_run),
    .i_toggle    (w_toggle),
    .o_half_tick (w_half_tick),
    .o_sclk      (w_sclk)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit;
    w_ch_nxt     = r_ch;
    w_prev_nxt   = r_prev_ch;
    w_shreg_nxt  = r_shreg;
    w_cs_n_nxt   = r_cs_n;
    w_saddr_nxt  = r_saddr;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    w_sample_nxt = r_sample;
    w_chan_nxt   = r_channel;
    w_restart    = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (r_state == DONE) begin
          w_prev_nxt = r_ch;
        end
        w_state_nxt = IDLE;
        if (w_accept) begin
          w_state_nxt = SETUP;
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_ch_nxt    = channel_i;
          w_bit_nxt   = 4'd0;
          w_shreg_nxt = '0;
          w_restart   = 1'b1;
        end
      end

      SETUP: begin
        if (w_half_tick) begin
          w_state_nxt = SHIFT;
          w_saddr_nxt = addr_bit(4'd0, r_ch);
        end
      end

      SHIFT: begin
        // Work happens at the end of each high half: capture, then either
        // advance to the next bit (SCLK falls) or close the frame.
        if (w_half_tick && w_sclk) begin
          if (r_bit >= c_lead) begin
            w_shreg_nxt = {r_shreg[ADC_BITS-2:0], r_sdat_q};
          end
          if (r_bit == c_last_bit) begin
            w_state_nxt = HOLD;
            w_cs_n_nxt  = 1'b1;
            w_saddr_nxt = 1'b0;
          end else begin
            w_bit_nxt   = r_bit + 4'd1;
            w_saddr_nxt = addr_bit(r_bit + 4'd1, r_ch);
          end
        end
      end

      HOLD: begin
        if (w_half_tick) begin
          w_state_nxt  = DONE;
          w_valid_nxt  = 1'b1;
          w_busy_nxt   = 1'b0;
          w_sample_nxt = r_shreg;
          w_chan_nxt   = r_prev_ch;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cs_n_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit     <= 4'd0;
      r_ch      <= '0;
      r_prev_ch <= '0;
      r_shreg   <= '0;
      r_sdat_q  <= 1'b0;
      r_cs_n    <= 1'b1;
      r_saddr   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_sample  <= '0;
      r_channel <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit     <= w_bit_nxt;
      r_ch      <= w_ch_nxt;
      r_prev_ch <= w_prev_nxt;
      r_shreg   <= w_shreg_nxt;
      r_sdat_q  <= ADC_SDAT;
      r_cs_n    <= w_cs_n_nxt;
      r_saddr   <= w_saddr_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_sample  <= w_sample_nxt;
      r_channel <= w_chan_nxt;
    end
  end

  assign sample_o  = r_sample;
  assign channel_o = r_channel;
  assign valid_o   = r_valid;
  assign busy_o    = r_busy;
  assign ADC_CS_N  = r_cs_n;
  assign ADC_SCLK  = w_sclk;
  assign ADC_SADDR = r_saddr;

endmodule
`default_nettype wire

// File: tb/tb_adc128s022_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc128s022_reader
//  Purpose  : Self-checking bench for adc128s022_reader with a behavioural
//             ADC model (CLK_DIV=2) and a framing instance (CLK_DIV=13).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc128s022_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  channel_i;
  logic [11:0] sample_o;
  logic [2:0]  channel_o;
  logic        valid_o, busy_o, adc_cs_n, adc_sclk, adc_saddr;
  logic        adc_sdat = 1'b0;

  logic        start13;
  logic [2:0]  ch13;
  logic [11:0] sample13;
  logic [2:0]  chan13;
  logic        valid13, busy13, cs13, sclk13, saddr13;
  logic        sdat13;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc128s022_reader #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .channel_i(channel_i),
    .sample_o(sample_o), .channel_o(channel_o), .valid_o(valid_o), .busy_o(busy_o),
    .ADC_CS_N(adc_cs_n), .ADC_SCLK(adc_sclk), .ADC_SADDR(adc_saddr), .ADC_SDAT(adc_sdat)
  );

  adc128s022_reader #(.CLK_DIV(13)) dut13 (
    .clk(clk), .reset(reset), .start_i(start13), .channel_i(ch13),
    .sample_o(sample13), .channel_o(chan13), .valid_o(valid13), .busy_o(busy13),
    .ADC_CS_N(cs13), .ADC_SCLK(sclk13), .ADC_SADDR(saddr13), .ADC_SDAT(sdat13)
  );

  // ---------------- ADC model: DOUT changes on SCLK falls ----------------
  logic [11:0] model_data = 12'h000;
  logic [2:0]  saddr_seen = 3'b000;
  int          fall_k = 0;
  int          rise_k = 0;

  always @(negedge adc_cs_n) begin
    fall_k     = 0;
    rise_k     = 0;
    saddr_seen = 3'b000;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      #1;
      if (fall_k >= 4 && fall_k <= 15) adc_sdat = model_data[4'(15 - fall_k)];
      else adc_sdat = 1'b0;
      fall_k++;
    end
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      if (rise_k >= 2 && rise_k <= 4) saddr_seen[2'(4 - rise_k)] = adc_saddr;
      rise_k++;
    end
  end

  // ---------------- pulse / window monitor ----------------
  int   valid_cnt = 0;
  int   cs_fall_cnt = 0;
  logic cs_prev = 1'b1;

  always @(negedge clk) begin
    if (valid_o === 1'b1) valid_cnt++;
    if (cs_prev === 1'b1 && adc_cs_n === 1'b0) cs_fall_cnt++;
    cs_prev = adc_cs_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a frame in the current cycle and returns in the valid_o cycle.
  task automatic run_frame(input logic [2:0] ch, input logic [11:0] data,
                           input logic [11:0] exp_s, input logic [2:0] exp_c,
                           input string tag);
    int n;
    model_data = data;
    channel_i  = ch;
    start_i    = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    channel_i = ~ch;
    n = 1;
    while (valid_o !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 69);
    check({tag, " sample_o"}, sample_o, exp_s);
    check({tag, " channel_o"}, channel_o, exp_c);
    check({tag, " busy_o in valid cycle"}, busy_o, 1'b0);
    check({tag, " saddr bits"}, saddr_seen, ch);
    check({tag, " sclk rises"}, rise_k, 16);
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
    logic [11:0] exp_sample;
    logic [2:0]  exp_ch;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   n, run, bad, rises;
    logic prev_s;

    vecs[0] = '{3'd5, 12'hA5C, 12'hA5C, 3'd0};
    vecs[1] = '{3'd3, 12'h123, 12'h123, 3'd5};
    vecs[2] = '{3'd7, 12'hFFF, 12'hFFF, 3'd3};
    vecs[3] = '{3'd0, 12'h000, 12'h000, 3'd7};
    vecs[4] = '{3'd2, 12'h801, 12'h801, 3'd0};

    reset = 1'b1; start_i = 1'b0; channel_i = 3'd0;
    start13 = 1'b0; ch13 = 3'd0; sdat13 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset cs_n", adc_cs_n, 1'b1);
    check("reset sclk", adc_sclk, 1'b1);
    check("reset saddr", adc_saddr, 1'b0);
    check("reset valid", valid_o, 1'b0);
    check("reset busy", busy_o, 1'b0);
    check("reset sample", sample_o, 12'h000);
    check("reset channel", channel_o, 3'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back frames: each start is issued in the previous valid cycle.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].ch, vecs[i].data, vecs[i].exp_sample, vecs[i].exp_ch,
                $sformatf("frame%0d", i));
    end
    @(negedge clk);
    check("valid pulse width", valid_o, 1'b0);
    repeat (5) @(negedge clk);

    // Start while busy is ignored and not queued.
    valid_cnt = 0; cs_fall_cnt = 0;
    model_data = 12'h3C3; channel_i = 3'd6; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    channel_i = 3'd1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (150) @(negedge clk);
    check("busy start valid count", valid_cnt, 1);
    check("busy start cs windows", cs_fall_cnt, 1);
    check("busy start sample", sample_o, 12'h3C3);
    check("busy start channel", channel_o, 3'd2);
    check("busy start saddr", saddr_seen, 3'd6);

    // Reset mid-frame.
    model_data = 12'h555; channel_i = 3'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset cs_n", adc_cs_n, 1'b1);
    check("midreset sclk", adc_sclk, 1'b1);
    check("midreset saddr", adc_saddr, 1'b0);
    check("midreset busy", busy_o, 1'b0);
    check("midreset valid", valid_o, 1'b0);
    check("midreset sample", sample_o, 12'h000);
    check("midreset channel", channel_o, 3'd0);
    reset = 1'b0;
    valid_cnt = 0;
    repeat (100) @(negedge clk);
    check("midreset no valid", valid_cnt, 0);
    run_frame(3'd1, 12'h0F0, 12'h0F0, 3'd0, "post_reset");
    repeat (3) @(negedge clk);

    // Framing at CLK_DIV=13 (DOUT tied high, leading bits ignored).
    ch13 = 3'd3; start13 = 1'b1;
    @(negedge clk);
    start13 = 1'b0;
    n = 1; run = 0; bad = 0; rises = 0; prev_s = 1'b1;
    while (valid13 !== 1'b1 && n < 1000) begin
      if (cs13 === 1'b0) begin
        if (sclk13 !== prev_s) begin
          if (run != 13) bad++;
          if (sclk13 === 1'b1) rises++;
          run = 1;
        end else begin
          run++;
        end
      end else if (sclk13 !== prev_s) begin
        bad++;
      end
      prev_s = sclk13;
      @(negedge clk);
      n++;
    end
    check("div13 latency", n, 443);
    check("div13 sclk rises", rises, 16);
    check("div13 half-period errors", bad, 0);
    check("div13 sample", sample13, 12'hFFF);
    check("div13 channel", chan13, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
